arb_requester: RTL

//  Requester-side agent for one pipeline on the 2-way round-robin shared-resource arbiter.

---
 rtl/arb_pkg.sv | 26 ++
 rtl/arb_cmd_fifo.sv | 71 +++++++
 rtl/arb_requester.sv | 105 ++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared defaults and helpers for the arbiter requester slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package arb_pkg;

    localparam int ARB_DATA_W       = 32;
    localparam int ARB_DEPTH        = 4;
    localparam int ARB_STARVE_LIMIT = 16;

    // Ceiling log2. Returns at least 1 so a 1-bit field is always legal.
    function automatic int arb_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/arb_cmd_fifo.sv
// Synchronous command FIFO, DEPTH x DATA_W, with head, occupancy and flags.
// Latency: a pushed entry appears at head on the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; no push-through.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset (flushes pointers)
//   push, push_data     write request and payload
//   pop                 retire the head entry
//   head                current head payload (valid while !empty)
//   count, full, empty  occupancy and its decoded flags
module arb_cmd_fifo
    import arb_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W,
    parameter int DEPTH  = ARB_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [DATA_W-1:0]            head,
    output logic [arb_clog2(DEPTH):0]    count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW    = arb_clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage has no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/arb_requester.sv
// Requester agent: queues pipeline commands, requests the arbiter, issues one command per grant.
// Latency: grant -> out_valid/out_data 1 cycle; push -> req visible next cycle.
// Backpressure: in_ready low while the queue is full, even if a grant pops that cycle.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset (drops queued commands)
//   in_valid/in_ready     pipeline command handshake, in_data payload
//   req, grant            arbiter request (combinational) and registered grant
//   out_valid, out_data   command issued to the shared resource
//   starve_o              one-cycle pulse after STARVE_LIMIT unserved request cycles
//   err_o                 sticky: grant arrived with nothing queued
module arb_requester
    import arb_pkg::*;
#(
    parameter int DATA_W       = ARB_DATA_W,
    parameter int DEPTH        = ARB_DEPTH,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              req,
    input  logic              grant,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              starve_o,
    output logic              err_o
);

    localparam int CNT_W = arb_clog2(DEPTH) + 1;
    localparam int SC_W  = arb_clog2(STARVE_LIMIT + 1);

    logic [DATA_W-1:0] head;
    logic [CNT_W-1:0]  count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [SC_W-1:0]   starve_cnt;
    logic              starve_hit;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = grant && !fifo_empty;

    arb_cmd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The arbiter samples req on the same edge that retires the current
    // grant, so the entry being consumed right now must not be counted:
    // with one entry left and a grant in flight, req drops to avoid a
    // second grant that would find the queue empty.
    assign req = (count > {{(CNT_W-1){1'b0}}, grant});

    // The pulse fires during the STARVE_LIMIT-th consecutive unserved cycle;
    // the counter then restarts so a long stall pulses every STARVE_LIMIT cycles.
    assign starve_hit = req && !grant && (starve_cnt == SC_W'(STARVE_LIMIT - 1));
    assign starve_o   = starve_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!req || grant || starve_hit) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Issue register: out_data holds the last issued command between pops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= pop;
            if (pop) begin
                out_data <= head;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_o <= 1'b0;
        end else if (grant && fifo_empty) begin
            err_o <= 1'b1;
        end
    end

endmodule
